// File: rtl/rsa_result_collector.sv
// Collects the westward result streams of every RSA array row, buffers each
// row in its own small FIFO and round-robins the rows onto one write port,
// storing the result matrix row-major starting at a latched base address.
module rsa_result_collector #(
   parameter int RSA_DW     = 16,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 10,
   parameter int ROW_STRIDE = 4
) (
   input  logic                   clk,
   input  logic                   sys_rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ROWS-1:0]        mulres_val,
   input  logic [ROWS*RSA_DW-1:0] mulres,
   output logic                   wr_en,
   input  logic                   wr_ready,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [RSA_DW-1:0]      wr_data,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic                   err_extra
);

   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int AW    = $clog2(COLS + 1);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int NW    = $clog2(FIFO_DEPTH + 1);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int TOTAL = ROWS * COLS;
   localparam int WW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [RSA_DW-1:0] fifo_data [ROWS][FIFO_DEPTH];
   logic [CW-1:0]     fifo_col  [ROWS][FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr    [ROWS];
   logic [PW-1:0]     wr_ptr    [ROWS];
   logic [NW-1:0]     fifo_cnt  [ROWS];
   logic [AW-1:0]     arr_cnt   [ROWS];

   logic [WW-1:0]     wr_cnt;
   logic [RW-1:0]     rr_ptr;
   logic [RW-1:0]     grant;
   logic [RW-1:0]     cand;
   logic [RW-1:0]     lock_row;
   logic              lock;
   logic              found;
   logic [ADDR_W-1:0] base_q;
   logic              overflow_q;
   logic              err_q;

   logic [ROWS-1:0]   not_empty;
   logic [ROWS-1:0]   full;
   logic [ROWS-1:0]   push;
   logic [ROWS-1:0]   pop;
   logic [ROWS-1:0]   arr_inc;
   logic [ROWS-1:0]   drop_full;
   logic [ROWS-1:0]   drop_extra;
   logic              in_collect;
   logic              accept_start;
   logic              xfer;
   logic [RSA_DW-1:0] head_data;
   logic [CW-1:0]     head_col;

   assign in_collect   = (state_q == S_COLLECT);
   assign accept_start = (state_q == S_IDLE) && start;
   assign overflow     = overflow_q;
   assign err_extra    = err_q;

   // Per-row FIFO status and the arrival decision: push, drop on full, or drop as unexpected
   always_comb begin
      not_empty  = '0;
      full       = '0;
      push       = '0;
      arr_inc    = '0;
      drop_full  = '0;
      drop_extra = '0;
      for (int r = 0; r < ROWS; r++) begin
         not_empty[r] = (fifo_cnt[r] != '0);
         full[r]      = (fifo_cnt[r] == NW'(FIFO_DEPTH));
         if (mulres_val[r]) begin
            if (!in_collect || (arr_cnt[r] == AW'(COLS))) begin
               drop_extra[r] = 1'b1;
            end else begin
               arr_inc[r] = 1'b1;
               if (full[r] && !pop[r]) begin
                  drop_full[r] = 1'b1;
               end else begin
                  push[r] = 1'b1;
               end
            end
         end
      end
   end

   // Round-robin grant from rr_ptr upward; a stalled grant stays locked so no row can steal it
   always_comb begin
      grant = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < ROWS; i++) begin
         cand = RW'((int'(rr_ptr) + i) % ROWS);
         if (!found && not_empty[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
      if (lock) begin
         grant = lock_row;
      end
   end

   // Write port: head of the granted FIFO, address forced to zero when idle
   always_comb begin
      head_data = fifo_data[grant][rd_ptr[grant]];
      head_col  = fifo_col[grant][rd_ptr[grant]];
      wr_en     = in_collect && (|not_empty);
      xfer      = wr_en && wr_ready;
      pop       = '0;
      wr_addr   = '0;
      wr_data   = '0;
      if (xfer) begin
         pop[grant] = 1'b1;
      end
      if (wr_en) begin
         wr_addr = base_q + ADDR_W'(int'(grant) * ROW_STRIDE) + ADDR_W'(head_col);
         wr_data = head_data;
      end
   end

   // FSM next state and status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            busy = 1'b1;
            if (xfer && (wr_cnt == WW'(TOTAL - 1))) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register, write counter, round-robin pointer, grant lock and base latch
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q  <= S_IDLE;
         wr_cnt   <= '0;
         rr_ptr   <= '0;
         base_q   <= '0;
         lock     <= 1'b0;
         lock_row <= '0;
      end else begin
         state_q  <= state_d;
         lock     <= wr_en && !wr_ready;
         lock_row <= grant;
         if (accept_start) begin
            base_q <= base_addr;
            wr_cnt <= '0;
            rr_ptr <= '0;
         end else if (xfer) begin
            wr_cnt <= wr_cnt + WW'(1);
            rr_ptr <= (grant == RW'(ROWS - 1)) ? '0 : grant + RW'(1);
         end
      end
   end

   // FIFO pointers, occupancy, per-row arrival counters and sticky error flags
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         for (int r = 0; r < ROWS; r++) begin
            rd_ptr[r]   <= '0;
            wr_ptr[r]   <= '0;
            fifo_cnt[r] <= '0;
            arr_cnt[r]  <= '0;
         end
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (accept_start) begin
               rd_ptr[r]   <= '0;
               wr_ptr[r]   <= '0;
               fifo_cnt[r] <= '0;
               arr_cnt[r]  <= '0;
            end else begin
               if (push[r]) begin
                  wr_ptr[r] <= wr_ptr[r] + PW'(1);
               end
               if (pop[r]) begin
                  rd_ptr[r] <= rd_ptr[r] + PW'(1);
               end
               if (push[r] && !pop[r]) begin
                  fifo_cnt[r] <= fifo_cnt[r] + NW'(1);
               end else if (!push[r] && pop[r]) begin
                  fifo_cnt[r] <= fifo_cnt[r] - NW'(1);
               end
               if (arr_inc[r]) begin
                  arr_cnt[r] <= arr_cnt[r] + AW'(1);
               end
            end
         end
         overflow_q <= (accept_start ? 1'b0 : overflow_q) | (|drop_full);
         err_q      <= (accept_start ? 1'b0 : err_q) | (|drop_extra);
      end
   end

   // FIFO storage: result word plus its column tag
   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (push[r]) begin
            fifo_data[r][wr_ptr[r]] <= mulres[r*RSA_DW +: RSA_DW];
            fifo_col[r][wr_ptr[r]]  <= arr_cnt[r][CW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_rsa_result_collector.sv
// Directed bench for rsa_result_collector: nominal skewed run, backpressure,
// fairness, overflow on a shallow-FIFO instance, unexpected words and
// address wrap / mid-run reset.
module tb_rsa_result_collector;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [3:0]  mulres_val;
   logic [63:0] mulres;
   logic        wr_ready;

   logic        wr_en, busy, done, overflow, err_extra;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;

   logic        wr_en_2, busy_2, done_2, overflow_2, err_extra_2;
   logic [9:0]  wr_addr_2;
   logic [15:0] wr_data_2;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   logic [9:0]  xa[$];
   logic [15:0] xd[$];
   logic [9:0]  xa2[$];
   logic [15:0] xd2[$];
   int          done_cnt, done_cyc, last_xfer_cyc, done2_cnt;
   logic        mon_en  = 1'b0;
   logic        mon2_en = 1'b0;
   logic        stall_prev = 1'b0;
   logic [9:0]  stall_addr;
   logic [15:0] stall_data;

   rsa_result_collector #(
      .RSA_DW(16), .ROWS(4), .COLS(4), .FIFO_DEPTH(4), .ADDR_W(10), .ROW_STRIDE(4)
   ) dut (
      .clk(clk), .sys_rst(sys_rst), .start(start), .base_addr(base_addr),
      .mulres_val(mulres_val), .mulres(mulres),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .overflow(overflow), .err_extra(err_extra)
   );

   rsa_result_collector #(
      .RSA_DW(16), .ROWS(4), .COLS(4), .FIFO_DEPTH(2), .ADDR_W(10), .ROW_STRIDE(4)
   ) dut2 (
      .clk(clk), .sys_rst(sys_rst), .start(start), .base_addr(base_addr),
      .mulres_val(mulres_val), .mulres(mulres),
      .wr_en(wr_en_2), .wr_ready(wr_ready), .wr_addr(wr_addr_2), .wr_data(wr_data_2),
      .busy(busy_2), .done(done_2), .overflow(overflow_2), .err_extra(err_extra_2)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time done against the last transfer
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Records transfers and done pulses of the main instance and checks stall stability
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            checkOutput("stall_wr_en", 32'(wr_en), 32'd1);
            checkOutput("stall_addr", 32'(wr_addr), 32'(stall_addr));
            checkOutput("stall_data", 32'(wr_data), 32'(stall_data));
         end
         if (wr_en && wr_ready) begin
            xa.push_back(wr_addr);
            xd.push_back(wr_data);
            last_xfer_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = wr_en && !wr_ready;
         stall_addr = wr_addr;
         stall_data = wr_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Records transfers and done pulses of the shallow-FIFO instance
   always @(negedge clk) begin
      if (mon2_en) begin
         if (wr_en_2 && wr_ready) begin
            xa2.push_back(wr_addr_2);
            xd2.push_back(wr_data_2);
         end
         if (done_2) done2_cnt++;
      end
   end

   // Watchdog so the bench can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearMon();
      xa.delete(); xd.delete(); xa2.delete(); xd2.delete();
      done_cnt = 0; done_cyc = 0; last_xfer_cyc = 0; done2_cnt = 0;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d);
      mulres_val = v;
      mulres     = d;
      @(posedge clk); #1;
   endtask

   task automatic doReset();
      mon_en = 1'b0; mon2_en = 1'b0;
      sys_rst = 1'b1; start = 1'b0; base_addr = '0;
      mulres_val = '0; mulres = '0; wr_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sys_rst = 1'b0;
      clearMon();
   endtask

   task automatic doStart(input logic [9:0] b);
      start = 1'b1; base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Skewed pattern: row r sends column c at step r+c with data 16*r+c
   task automatic buildVec(input int t, output logic [3:0] v, output logic [63:0] d);
      int c;
      v = '0; d = '0;
      for (int r = 0; r < 4; r++) begin
         c = t - r;
         if (c >= 0 && c < 4) begin
            v[r] = 1'b1;
            d[r*16 +: 16] = 16'(16 * r + c);
         end
      end
   endtask

   task automatic sendSkewed(input int t0, input int sf, input int sl, input int n);
      logic [3:0]  v;
      logic [63:0] d;
      for (int t = t0; t < n; t++) begin
         wr_ready = !(t >= sf && t < sf + sl);
         buildVec(t, v, d);
         applyStimulus(v, d);
      end
      wr_ready = 1'b1;
      applyStimulus('0, '0);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (done_cnt == 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      mon_en = 1'b0;
   endtask

   task automatic checkNominal(input string tag, input logic [9:0] base);
      logic [15:0] seen;
      int lastc[4];
      int r, c;
      seen = '0;
      for (int i = 0; i < 4; i++) lastc[i] = -1;
      checkOutput({tag, "_count"}, 32'(xa.size()), 32'd16);
      for (int k = 0; k < xd.size(); k++) begin
         r = int'(xd[k][7:4]);
         c = int'(xd[k][3:0]);
         if (xd[k] < 16'h40 && c < 4) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), 32'(xa[k]),
                        32'((int'(base) + 4 * r + c) & 'h3FF));
            checkOutput($sformatf("%s_order%0d", tag, k), 32'(c), 32'(lastc[r] + 1));
            lastc[r] = c;
            seen[r*4+c] = 1'b1;
         end else begin
            checkOutput($sformatf("%s_range%0d", tag, k), 32'(xd[k]), 32'd0);
         end
      end
      checkOutput({tag, "_seen"}, 32'(seen), 32'hFFFF);
      checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      checkOutput({tag, "_done_lat"}, 32'(done_cyc - last_xfer_cyc), 32'd1);
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
      checkOutput({tag, "_err_extra"}, 32'(err_extra), 32'd0);
      checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [3:0]  v;
      logic [63:0] d;

      // Reset state
      doReset();
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_err_extra", 32'(err_extra), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);

      // Nominal skewed run with first-word latency check
      doStart(10'h100);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      mon_en = 1'b1;
      buildVec(0, v, d);
      checkOutput("t1_empty_wr_en", 32'(wr_en), 32'd0);
      applyStimulus(v, d);
      checkOutput("t1_lat_wr_en", 32'(wr_en), 32'd1);
      checkOutput("t1_lat_addr", 32'(wr_addr), 32'h100);
      checkOutput("t1_lat_data", 32'(wr_data), 32'h0);
      sendSkewed(1, 0, 0, 7);
      waitDone();
      checkNominal("t1", 10'h100);

      // Backpressure for 10 cycles mid-burst; a start in COLLECT is ignored
      clearMon();
      doStart(10'h100);
      mon_en = 1'b1;
      start = 1'b1; base_addr = 10'h2A0;
      applyStimulus('0, '0);
      start = 1'b0; base_addr = 10'h100;
      sendSkewed(0, 2, 10, 17);
      waitDone();
      checkNominal("t2", 10'h100);

      // Fairness: all rows valid together for four cycles
      clearMon();
      doStart(10'h040);
      mon_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d = '0;
         for (int r = 0; r < 4; r++) d[r*16 +: 16] = 16'(16 * r + k);
         applyStimulus(4'b1111, d);
      end
      applyStimulus('0, '0);
      waitDone();
      checkOutput("t3_count", 32'(xa.size()), 32'd16);
      for (int k = 0; k < xd.size() && k < 16; k++) begin
         checkOutput($sformatf("t3_data%0d", k), 32'(xd[k]), 32'(16 * (k % 4) + k / 4));
         checkOutput($sformatf("t3_addr%0d", k), 32'(xa[k]), 32'(10'h040 + 4 * (k % 4) + k / 4));
      end
      checkOutput("t3_done_cnt", 32'(done_cnt), 32'd1);

      // Overflow on the FIFO_DEPTH=2 instance
      doReset();
      doStart(10'h200);
      wr_ready = 1'b0;
      for (int k = 0; k < 4; k++) applyStimulus(4'b0001, 64'(16'hA0 + k));
      applyStimulus('0, '0);
      checkOutput("t4_overflow", 32'(overflow_2), 32'd1);
      checkOutput("t4_deep_no_overflow", 32'(overflow), 32'd0);
      checkOutput("t4_stall_addr", 32'(wr_addr_2), 32'h200);
      checkOutput("t4_stall_data", 32'(wr_data_2), 32'hA0);
      mon2_en = 1'b1;
      wr_ready = 1'b1;
      repeat (10) applyStimulus('0, '0);
      mon2_en = 1'b0;
      checkOutput("t4_count", 32'(xa2.size()), 32'd2);
      for (int k = 0; k < xa2.size() && k < 2; k++) begin
         checkOutput($sformatf("t4_addr%0d", k), 32'(xa2[k]), 32'(10'h200 + k));
         checkOutput($sformatf("t4_data%0d", k), 32'(xd2[k]), 32'(16'hA0 + k));
      end
      checkOutput("t4_no_done", 32'(done2_cnt), 32'd0);
      checkOutput("t4_busy", 32'(busy_2), 32'd1);
      checkOutput("t4_overflow_sticky", 32'(overflow_2), 32'd1);

      // Fifth word on row 2 is dropped and flagged
      doReset();
      doStart(10'h000);
      mon_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d = '0;
         d[47:32] = 16'(16'h20 + k);
         applyStimulus(4'b0100, d);
      end
      repeat (8) applyStimulus('0, '0);
      mon_en = 1'b0;
      checkOutput("t5_err_extra", 32'(err_extra), 32'd1);
      checkOutput("t5_count", 32'(xa.size()), 32'd4);
      for (int k = 0; k < xa.size() && k < 4; k++) begin
         checkOutput($sformatf("t5_addr%0d", k), 32'(xa[k]), 32'(8 + k));
         checkOutput($sformatf("t5_data%0d", k), 32'(xd[k]), 32'(16'h20 + k));
      end
      checkOutput("t5_no_done", 32'(done_cnt), 32'd0);

      // Valid while IDLE
      doReset();
      applyStimulus(4'b0001, 64'h55);
      checkOutput("t5_idle_err", 32'(err_extra), 32'd1);
      checkOutput("t5_idle_wr_en", 32'(wr_en), 32'd0);
      applyStimulus('0, '0);
      checkOutput("t5_idle_wr_en2", 32'(wr_en), 32'd0);
      checkOutput("t5_idle_busy", 32'(busy), 32'd0);
      doStart(10'h000);
      checkOutput("t5_start_clears_err", 32'(err_extra), 32'd0);

      // Address wrap at the top of the 10-bit space
      doReset();
      doStart(10'h3FE);
      mon_en = 1'b1;
      sendSkewed(0, 0, 0, 7);
      waitDone();
      checkNominal("t6_wrap", 10'h3FE);

      // Reset mid-run, then a fresh clean run
      doReset();
      doStart(10'h100);
      for (int t = 0; t < 3; t++) begin
         buildVec(t, v, d);
         applyStimulus(v, d);
      end
      checkOutput("t6_pre_rst_wr_en", 32'(wr_en), 32'd1);
      sys_rst = 1'b1;
      mulres_val = '0;
      @(posedge clk); #1;
      checkOutput("t6_rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_done", 32'(done), 32'd0);
      checkOutput("t6_rst_overflow", 32'(overflow), 32'd0);
      checkOutput("t6_rst_err_extra", 32'(err_extra), 32'd0);
      checkOutput("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("t6_rst_wr_data", 32'(wr_data), 32'd0);
      sys_rst = 1'b0;
      clearMon();
      doStart(10'h100);
      mon_en = 1'b1;
      sendSkewed(0, 0, 0, 7);
      waitDone();
      checkNominal("t6_fresh", 10'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rsa_result_collector.md
Name: rsa_result_collector

Overview:
- Sits on the west edge of the RSA array and receives the westward result streams (`mulres_val_W` / `mulres_W`) from the column-0 PE of every row.
- Each row emits COLS result words, column 0 first. Rows are skewed and gaps may appear.
- The block buffers each row in a small FIFO, round-robins the rows onto a single write port with a valid/ready handshake, and writes the result matrix row-major.
- It pulses `done` once all ROWS*COLS words are written.

Parameters:
- RSA_DW, 16, data width (matches PE datapath)
- ROWS, 4, number of array rows
- COLS, 4, number of array columns (results per row)
- FIFO_DEPTH, 4, entries per row FIFO (power of 2, >=2)
- ADDR_W, 10, write address width
- ROW_STRIDE, 4, address distance between result rows

Ports:
- clk  input  1  system clock, single clock domain
- sys_rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: begin a collection (honoured in IDLE only)
- base_addr  input  ADDR_W  result base address, latched on accepted start
- mulres_val  input  ROWS  per-row result valid (bit r = row r)
- mulres  input  ROWS*RSA_DW  per-row result data, row r at [r*RSA_DW +: RSA_DW], signed
- wr_en  output  1  write request valid
- wr_ready  input  1  sink accepts; a transfer occurs when wr_en && wr_ready
- wr_addr  output  ADDR_W  write address
- wr_data  output  RSA_DW  write data
- busy  output  1  high in COLLECT
- done  output  1  one-cycle pulse, collection complete
- overflow  output  1  sticky: a word was dropped on a full FIFO
- err_extra  output  1  sticky: more than COLS words arrived on a row, or a valid arrived outside COLLECT

Behaviour:
- Reset: all outputs 0; FIFOs emptied; counters, rr_ptr and latched base cleared; state IDLE. Reset mid-collection aborts it with no done.
- States:
  - IDLE: start -> COLLECT. On this transition: latch base_addr; clear per-row arrival counters, write counter, overflow and err_extra; rr_ptr=0.
  - COLLECT: busy=1. When the write counter reaches ROWS*COLS after a transfer -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- Arrival, per row r, in COLLECT:
  - If mulres_val[r]=1, the word is tagged with col = arrival_cnt[r] and arrival_cnt[r] increments.
  - If arrival_cnt[r]==COLS, the word is dropped and err_extra set.
  - If FIFO r is full, the word is dropped, overflow set, and arrival_cnt still increments, so later columns keep correct addresses.
- Push and pop of the same FIFO in one cycle is legal: count is unchanged and the push succeeds even when full.
- A valid arriving in IDLE or DONE is dropped and sets err_extra.
- Arbitration:
  - Combinational from FIFO heads. Grant the first non-empty row searching from rr_ptr upward, wrapping at ROWS.
  - wr_en=1 whenever any FIFO is non-empty in COLLECT.
  - wr_data = head data.
  - wr_addr = base + row*ROW_STRIDE + col, truncated mod 2^ADDR_W.
- Stability: while wr_en && !wr_ready, the grant, wr_addr and wr_data are held unchanged. A newly non-empty higher-priority row must not steal the grant.
- On a transfer: pop the granted FIFO, rr_ptr <= (grant+1) mod ROWS, write counter increments.
- Latency: a word arriving at cycle t can appear on wr_en/wr_data at cycle t+1 at the earliest.
- Throughput: one word per cycle when wr_ready=1.
- done is asserted in the cycle after the final transfer.
- If words were dropped, done never asserts. Recovery is by sys_rst only; start is ignored while not in IDLE.

Test Plan:
1. Nominal run (ROWS=COLS=4, base=0x100, wr_ready=1): each row bursts 4 words with row r skewed r cycles, data=16*r+c -> 16 writes at addr 0x100+4r+c with matching data; done one cycle after the last transfer; overflow=err_extra=0.
2. Backpressure: wr_ready low for 10 cycles during the burst -> wr_en/wr_addr/wr_data constant while stalled; no drops with FIFO_DEPTH=4; all 16 writes complete.
3. Fairness: all 4 rows valid in the same cycle for 4 cycles, wr_ready=1 -> first four grants are rows 0,1,2,3, then order rotates; per-row column order is preserved.
4. Overflow (FIFO_DEPTH=2): wr_ready=0, row 0 sends 4 words -> columns 2 and 3 dropped, overflow=1. Release wr_ready -> addrs base+0 and base+1 written only; done never asserts.
5. Extra/unexpected words: a 5th word on row 2 -> err_extra=1 and not written. A valid while IDLE -> err_extra=1, wr_en stays 0.
6. Boundaries: base=0x3FE with ADDR_W=10 -> row 0 col 2 writes addr 0x000. Assert sys_rst mid-run -> all outputs 0 next cycle; a fresh start completes cleanly.
